uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  UART transmitter: serialises bytes from a valid/ready source onto txd
//  (start, LSB-first data, optional parity, stop). Consumes the 1-clk
//  bit-rate tick from uart_baud, one bit per tick. Includes a one-entry
//  holding register, so the next byte is accepted while the current frame
//  shifts. Frames are back-to-back with no idle gap.
// PARAMETERS
//  DATA_BITS  8  data bits per frame, 5..8
//  PARITY     0  0 = none, 1 = odd, 2 = even
//  STOP_BITS  1  stop bits per frame, 1 or 2
// PORTS
//  clk       in   1          system clock
//  rst       in   1          reset, synchronous, active-high
//  baud      in   1          bit tick from uart_baud; 1-clk pulse, +/-1 clk jitter
//  tx_data   in   DATA_BITS  byte to send; sampled when tx_valid & tx_ready
//  tx_valid  in   1          source has data
//  tx_ready  out  1          holding register empty: = !hold_full & !rst
//  txd       out  1          serial line, registered, idle high
//  busy      out  1          state != IDLE | hold_full
// BEHAVIOUR
//  Reset values (rst high at posedge): txd=1, state=IDLE, hold_full=0,
//  bit_cnt=0, stop_cnt=0. tx_ready is 0 while rst is high and 1 after.
//  Rst mid-frame truncates the frame: txd=1 at the next edge, and any held
//  byte is discarded.
//  Accept: tx_valid & tx_ready at posedge -> hold <= tx_data, hold_full <= 1.
//  Each baud=1 cycle counts as one tick; there is no edge detection.
//  States advance only on cycles with baud=1; otherwise all state holds.
//  FSM IDLE/START/DATA/PAR/STOP, with txd updated on the same edge:
//   IDLE : tick & hold_full -> shift <= hold, hold_full <= 0, txd <= 0,
//          go to START. Otherwise txd = 1.
//   START: tick -> txd <= shift[0], bit_cnt <= 0, go to DATA.
//   DATA : tick -> if bit_cnt == DATA_BITS-1:
//                    PARITY != 0 -> txd <= par, go to PAR
//                    PARITY == 0 -> txd <= 1, stop_cnt <= 0, go to STOP
//                  else txd <= shift[bit_cnt+1], bit_cnt++.
//   PAR  : tick -> txd <= 1, stop_cnt <= 0, go to STOP.
//   STOP : tick -> if stop_cnt == STOP_BITS-1:
//                    hold_full -> load the held byte, txd <= 0, go to START
//                    else go to IDLE
//                  else stop_cnt++.
//  Parity: par = ^shift[DATA_BITS-1:0] for even, ~^ for odd.
//  Each line bit lasts exactly one tick-to-tick interval.
//  Same-cycle rules:
//   - Accept on a tick edge while IDLE and empty: the byte lands in hold.
//     The start bit waits for the next tick; acceptance and launch never
//     coincide.
//   - Hold is consumed on a tick edge while tx_valid=1: no accept that
//     cycle (tx_ready was 0). tx_ready reads 1 the next cycle.
//   - tx_data must be stable only in the accept cycle. shift is
//     independent of hold after the load.
//  Latency: accept -> start bit on txd at the first tick after the accept
//  edge.
// TESTING
//  1 8N1, baud every 10 clk, send 0x55 -> txd 0,1,0,1,0,1,0,1,0,1 at 10 clk
//    each, then idle 1; busy=1 from accept to the end of stop.
//  2 Send 0xA5 then 0x3C with the second accepted mid-frame -> 0x3C start
//    bit begins on the tick ending 0xA5's stop bit; no gap; tx_ready=0 in
//    between.
//  3 PARITY=2, 0x07 -> parity bit 1. PARITY=1, 0x07 -> parity bit 0.
//    PARITY=2, 0x00 -> 0.
//  4 STOP_BITS=2, DATA_BITS=7, send 0x7F -> 7 ones, then txd high for 2
//    ticks before the next start.
//  5 rst during data bit 3 -> txd=1 the next clk, busy=0, tx_ready=1 after
//    release; a new byte sends cleanly.
//  6 tx_valid on a tick cycle in IDLE -> txd stays 1 this tick; start bit
//    at the following tick.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: serialises bytes from a valid/ready source onto txd as
// start, LSB-first data, optional parity and stop bits, one bit per baud tick.
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 busy
);

    localparam int                CNT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   hold_q, hold_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   hold_full_q, hold_full_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]       bit_cnt_nxt;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   txd_q, txd_d;
    logic                   par;

    // Even parity makes the total count of ones even, so the bit is the XOR.
    assign par         = (PARITY == 2) ? ^shift_q : ~^shift_q;
    assign bit_cnt_nxt = bit_cnt_q + CNT_ONE;

    assign tx_ready = ~hold_full_q & ~rst;
    assign busy     = (state_q != IDLE) | hold_full_q;
    assign txd      = txd_q;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d     = state_q;
        hold_d      = hold_q;
        shift_d     = shift_q;
        hold_full_d = hold_full_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        txd_d       = txd_q;

        // Accept and load are exclusive: tx_ready is low whenever hold is full.
        if (tx_valid && tx_ready) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        if (baud) begin
            unique case (state_q)
                IDLE: begin
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        txd_d       = 1'b0;
                        state_d     = START;
                    end else begin
                        txd_d = 1'b1;
                    end
                end
                START: begin
                    txd_d     = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
                DATA: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (PARITY != 0) begin
                            txd_d   = par;
                            state_d = PAR;
                        end else begin
                            txd_d      = 1'b1;
                            stop_cnt_d = 1'b0;
                            state_d    = STOP;
                        end
                    end else begin
                        txd_d     = shift_q[bit_cnt_nxt];
                        bit_cnt_d = bit_cnt_nxt;
                    end
                end
                PAR: begin
                    txd_d      = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
                STOP: begin
                    if (stop_cnt_q == LAST_STOP) begin
                        // Back-to-back frames: launch the held byte with no idle gap.
                        if (hold_full_q) begin
                            shift_d     = hold_q;
                            hold_full_d = 1'b0;
                            txd_d       = 1'b0;
                            state_d     = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
                default: begin
                    txd_d   = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            txd_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            txd_q       <= txd_d;
        end
    end

    // NOTE: data registers carry no reset; their contents are only used once the
    // reset-cleared control flags mark them valid.
    always_ff @(posedge clk) begin
        hold_q  <= hold_d;
        shift_q <= shift_d;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations (8N1, 8E1, 8O1, 7N2) driven by a
// directed sequence; expected line bits are queued at accept and popped per tick.
module tb_uart_tx;

    localparam int N        = 4;
    localparam int BAUD_DIV = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         baud;
    logic [7:0]   tx_data;
    logic [N-1:0] tx_valid;
    wire  [N-1:0] tx_ready;
    wire  [N-1:0] txd;
    wire  [N-1:0] busy;

    int errors   = 0;
    int checks   = 0;
    int baud_cnt = 0;
    int sel      = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .baud(baud), .tx_data(tx_data), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .txd(txd[0]), .busy(busy[0]));
    uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .baud(baud), .tx_data(tx_data), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .txd(txd[1]), .busy(busy[1]));
    uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .baud(baud), .tx_data(tx_data), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .txd(txd[2]), .busy(busy[2]));
    uart_tx #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst(rst), .baud(baud), .tx_data(tx_data[6:0]), .tx_valid(tx_valid[3]),
        .tx_ready(tx_ready[3]), .txd(txd[3]), .busy(busy[3]));

    function automatic int cfg_data_bits(int s);
        return (s == 3) ? 7 : 8;
    endfunction

    function automatic int cfg_parity(int s);
        return (s == 1) ? 2 : (s == 2) ? 1 : 0;
    endfunction

    function automatic int cfg_stop_bits(int s);
        return (s == 3) ? 2 : 1;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp_v);
        end
    endtask

    // Builds the full expected line sequence for one frame of the selected DUT.
    task automatic push_frame(input logic [7:0] d);
        bit p = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < cfg_data_bits(sel); i++) begin
            exp_q.push_back(d[i]);
            p = p ^ d[i];
        end
        if (cfg_parity(sel) == 2) exp_q.push_back(p);
        if (cfg_parity(sel) == 1) exp_q.push_back(~p);
        for (int i = 0; i < cfg_stop_bits(sel); i++) exp_q.push_back(1'b1);
    endtask

    // One clock: baud driven at negedge, txd compared after each tick edge.
    task automatic step();
        bit e_bit;
        @(negedge clk);
        baud     = (baud_cnt == BAUD_DIV - 1);
        baud_cnt = (baud_cnt == BAUD_DIV - 1) ? 0 : baud_cnt + 1;
        @(posedge clk);
        #1;
        if (baud) begin
            if (exp_q.size() == 0) begin
                check("txd_idle", txd[sel], 1'b1);
            end else begin
                e_bit = exp_q.pop_front();
                check("txd_bit", txd[sel], e_bit);
                check("busy_frame", busy[sel], 1'b1);
            end
        end
    endtask

    task automatic send(input logic [7:0] d);
        bit ready_before;
        int n = 0;
        tx_data       = d;
        tx_valid[sel] = 1'b1;
        do begin
            ready_before = tx_ready[sel];
            step();
            n++;
        end while (!ready_before && n < 400);
        tx_valid = '0;
        tx_data  = 8'($urandom);
        check("accept", ready_before, 1'b1);
        if (ready_before) push_frame(d);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 2000) begin
            step();
            n++;
        end
        check("drain_done", exp_q.size() == 0, 1'b1);
        repeat (BAUD_DIV) step();
        check("idle_busy", busy[sel], 1'b0);
        check("idle_txd", txd[sel], 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        baud     = 1'b0;
        tx_data  = '0;
        tx_valid = '0;

        // Reset state
        sel = 0;
        repeat (3) step();
        check("rst_txd", txd[0], 1'b1);
        check("rst_busy", busy[0], 1'b0);
        check("rst_ready", tx_ready[0], 1'b0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", tx_ready[0], 1'b1);

        // 8N1, 0x55
        send(8'h55);
        check("busy_after_accept", busy[0], 1'b1);
        drain();

        // Back-to-back: 0x3C accepted mid-frame of 0xA5, no idle gap
        send(8'hA5);
        send(8'h3C);
        check("ready_hold_full", tx_ready[0], 1'b0);
        drain();

        // Parity variants
        sel = 1;
        send(8'h07);
        drain();
        sel = 2;
        send(8'h07);
        drain();
        sel = 1;
        send(8'h00);
        drain();

        // 7 data bits, 2 stop bits, followed by a second frame
        sel = 3;
        send(8'h7F);
        send(8'h2A);
        drain();

        // Reset while data bit 3 is on the line
        sel = 0;
        send(8'hC3);
        for (int n = 0; n < 500 && exp_q.size() > 5; n++) step();
        check("mid_frame_busy", busy[0], 1'b1);
        rst = 1'b1;
        exp_q.delete();
        step();
        check("trunc_txd", txd[0], 1'b1);
        check("trunc_busy", busy[0], 1'b0);
        check("trunc_ready", tx_ready[0], 1'b0);
        rst = 1'b0;
        #1;
        check("ready_after_trunc", tx_ready[0], 1'b1);
        send(8'h96);
        drain();

        // Accept on a tick edge in IDLE: start waits for the following tick
        while (baud_cnt != BAUD_DIV - 1) step();
        send(8'h81);
        check("tick_accept_txd", txd[0], 1'b1);
        check("tick_accept_busy", busy[0], 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
